// File: rtl/ram_pkg.sv
// Shared sizes and types for the 32x32 single-port data memory.
//   DATA_WIDTH : bits per word
//   ADDR_WIDTH : word address bits
//   DEPTH      : number of words (2**ADDR_WIDTH)
package ram_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DEPTH      = 32'(1) << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : ram_pkg

// File: rtl/ram_32x32.sv
// Single-port, word-addressed data memory (32 words x 32 bits) for the
// single-cycle datapath. One address serves both the read and the write.
//
// Ports:
//   clk       : system clock, all state changes on the rising edge
//   rst       : synchronous active-high reset, clears every word
//   readWrite : 1 = write dataIN to mem[address] on the next rising edge
//   dataIN    : write data
//   address   : word address 0..31
//   dataOUT   : read data, mem[address]
//
// Build option RAM_REGISTERED_READ_EN: when defined, dataOUT is a register
// loaded every edge with the pre-edge word (read-first, 1-cycle latency)
// and cleared by rst. When undefined, dataOUT is a combinational read.
module ram_32x32
  import ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  readWrite,
  input  logic [DATA_WIDTH-1:0] dataIN,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] dataOUT
);

  word_t mem [DEPTH];

  // Storage: reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (readWrite) begin
      mem[address] <= dataIN;
    end
  end

`ifdef RAM_REGISTERED_READ_EN
  word_t readReg;

  // Read-first output register: samples the word as it was before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      readReg <= '0;
    end else begin
      readReg <= mem[address];
    end
  end

  assign dataOUT = readReg;
`else
  // Same-cycle read; no write-to-read bypass.
  assign dataOUT = mem[address];
`endif

endmodule : ram_32x32

// File: tb/tb_ram_32x32.sv
// Directed self-checking bench for ram_32x32 (both read-port builds).
module tb_ram_32x32;
  import ram_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  readWrite;
  word_t dataIN;
  addr_t address;
  word_t dataOUT;

  int unsigned errors = 0;
  int unsigned checks = 0;

  ram_32x32 dut (
    .clk       (clk),
    .rst       (rst),
    .readWrite (readWrite),
    .dataIN    (dataIN),
    .address   (address),
    .dataOUT   (dataOUT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t expected);
    checks++;
    assert (dataOUT === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, dataOUT, expected);
    end
  endtask

  // Read one word with readWrite=0, respecting the build's read latency.
  task automatic readCheck(input string tag, input addr_t a, input word_t expected);
    @(negedge clk);
    address   = a;
    readWrite = 1'b0;
`ifdef RAM_REGISTERED_READ_EN
    @(posedge clk);
`endif
    #1;
    check(tag, expected);
  endtask

  task automatic writeWord(input addr_t a, input word_t d);
    @(negedge clk);
    address   = a;
    dataIN    = d;
    readWrite = 1'b1;
    @(posedge clk);
    #1;
    readWrite = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    readWrite = 1'b0;
    dataIN    = '0;
    address   = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset clear: every address reads zero
    for (int a = 0; a < 32; a++) begin
      readCheck($sformatf("reset_clear[%0d]", a), addr_t'(a), '0);
    end

    // Write and read back
    writeWord(5'd29, 32'd24);
    writeWord(5'd30, 32'd46);
    readCheck("readback_29", 5'd29, 32'd24);
    readCheck("readback_30", 5'd30, 32'd46);
    readCheck("untouched_31", 5'd31, 32'd0);

    // readWrite=0 never modifies memory
    @(negedge clk);
    address   = 5'd21;
    dataIN    = 32'd90;
    readWrite = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    readCheck("readonly_21", 5'd21, 32'd0);
    @(negedge clk);
    dataIN = 32'd12;
    readCheck("readonly_4", 5'd4, 32'd0);

    // Boundary addresses
    writeWord(5'd0, 32'hDEAD_BEEF);
`ifdef RAM_REGISTERED_READ_EN
    writeWord(5'd31, 32'hFFFF_FFFF);
`else
    // Read-during-write on addr 31: old word before the edge, new one after
    @(negedge clk);
    address   = 5'd31;
    dataIN    = 32'hFFFF_FFFF;
    readWrite = 1'b1;
    #1;
    check("rdw_before_edge", 32'd0);
    @(posedge clk);
    #1;
    readWrite = 1'b0;
    check("rdw_after_edge", 32'hFFFF_FFFF);
`endif
    readCheck("boundary_0", 5'd0, 32'hDEAD_BEEF);
    readCheck("boundary_31", 5'd31, 32'hFFFF_FFFF);
    readCheck("neighbour_30", 5'd30, 32'd46);

    // Reset priority over a simultaneous write
    @(negedge clk);
    rst       = 1'b1;
    readWrite = 1'b1;
    address   = 5'd5;
    dataIN    = 32'd77;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    readWrite = 1'b0;
`ifdef RAM_REGISTERED_READ_EN
    check("reset_clears_outreg", 32'd0);
`endif
    readCheck("rst_prio_5", 5'd5, 32'd0);
    readCheck("rst_clear_0", 5'd0, 32'd0);
    readCheck("rst_clear_29", 5'd29, 32'd0);
    readCheck("rst_clear_30", 5'd30, 32'd0);
    readCheck("rst_clear_31", 5'd31, 32'd0);

`ifdef RAM_REGISTERED_READ_EN
    // One-cycle read latency: the write edge captured the pre-write word
    writeWord(5'd30, 32'd46);
    address = 5'd30;
    #1;
    check("latency_same_cycle", 32'd0);
    @(posedge clk);
    #1;
    check("latency_next_edge", 32'd46);
`else
    // dataOUT is valid while readWrite=1, before the write lands
    writeWord(5'd30, 32'd46);
    @(negedge clk);
    address   = 5'd30;
    dataIN    = 32'd99;
    readWrite = 1'b1;
    #1;
    check("read_in_write_mode", 32'd46);
    @(posedge clk);
    #1;
    readWrite = 1'b0;
    check("overwrite_30", 32'd99);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ram_32x32
